div_unsigned_iter: RTL and testbench

//  Unsigned fixed-point divider; the inverse operation of the team's unsigned fixed-point multiplier.

---
 rtl/div_unsigned_iter.sv | 155 +++++++++++++++
 tb/tb_div_unsigned_iter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/div_unsigned_iter.sv
// Unsigned fixed-point divider: out = floor(in1 / in2 * 2^WFO) by radix-2 restoring
// long division, one quotient bit per clock, with a start/busy/done handshake.
module div_unsigned_iter #(
    parameter int WI1 = 4,
    parameter int WF1 = 12,
    parameter int WI2 = 4,
    parameter int WF2 = 12,
    parameter int WIO = 8,
    parameter int WFO = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [WI1+WF1-1:0]   in1,
    input  logic [WI2+WF2-1:0]   in2,
    output logic                 busy,
    output logic                 done,
    output logic [WIO+WFO-1:0]   out,
    output logic                 ovf,
    output logic                 dz
);
    localparam int W1 = WI1 + WF1;
    localparam int W2 = WI2 + WF2;
    localparam int OW = WIO + WFO;
    localparam int SH = WFO + WF2 - WF1;
    localparam int WD = W1 + SH;
    localparam int WR = W2 + 1;
    localparam int CW = $clog2(WD + 1);
    localparam int QW = (WD > OW) ? WD : OW;

    generate
        if (WFO + WF2 < WF1) begin : g_bad_format
            $error("div_unsigned_iter: WFO+WF2 must be >= WF1");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [WD-1:0]   dvd_q, dvd_d;
    logic [W2-1:0]   dvs_q, dvs_d;
    logic [WR-1:0]   rem_q, rem_d;
    logic [WD-1:0]   quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [OW-1:0]   out_q, out_d;
    logic            ovf_q, ovf_d;
    logic            dz_q, dz_d;

    logic [WR:0]     rem_sh;
    logic [WR:0]     rem_nx;
    logic            q_bit;
    logic [WD-1:0]   quo_nx;
    logic [QW-1:0]   q_ext;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh = {rem_q, dvd_q[WD-1]};
        q_bit  = (rem_sh >= {2'b00, dvs_q});
        rem_nx = q_bit ? (rem_sh - {2'b00, dvs_q}) : rem_sh;
        quo_nx = WD'({quo_q, q_bit});
        q_ext  = QW'(quo_nx);
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (in2 == '0) begin
                        out_d  = '1;
                        dz_d   = 1'b1;
                        ovf_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        dvd_d   = WD'(in1) << SH;
                        dvs_d   = in2;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = CW'(WD - 1);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = WR'(rem_nx);
                quo_d = quo_nx;
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dz_d    = 1'b0;
                    state_d = IDLE;
                    // Quotient bits beyond the output width saturate the result.
                    if (|(q_ext >> OW)) begin
                        out_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        out_d = q_ext[OW-1:0];
                        ovf_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_div_unsigned_iter.sv
// Self-checking bench for div_unsigned_iter (default format, 24-cycle division).
module tb_div_unsigned_iter;
    localparam int WD = 24;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    wire         busy;
    wire         done;
    wire  [15:0] out;
    wire         ovf;
    wire         dz;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] prev_out = '0;

    div_unsigned_iter dut (
        .CLK   (CLK),
        .RST   (RST),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .ovf   (ovf),
        .dz    (dz)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the real-valued quotient scaled by 2^WFO.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic o, output logic z);
        longint unsigned num;
        longint unsigned quo;
        if (b == 16'h0000) begin
            q = 16'hFFFF; o = 1'b0; z = 1'b1;
        end else begin
            num = longint'(a) * 256;
            quo = num / longint'(b);
            z = 1'b0;
            if (quo > 65535) begin
                q = 16'hFFFF; o = 1'b1;
            end else begin
                q = quo[15:0]; o = 1'b0;
            end
        end
    endfunction

    // inj: run cycle at which a second start is pulsed; rst_at: run cycle at which RST drops.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int inj, input int rst_at);
        logic [15:0] eq;
        logic        eo;
        logic        ez;
        int          n;
        bit          busy_ok;
        model(a, b, eq, eo, ez);
        @(negedge CLK);
        in1 = a; in2 = b; start = 1'b1;
        @(posedge CLK); #1;
        n = 0;
        busy_ok = 1'b1;
        if (b != 16'h0000) begin
            chk("busy_on", busy, 1);
            chk("done_low", done, 0);
            chk("out_held", out, prev_out);
        end
        while (!done && n < 100) begin
            @(negedge CLK);
            start = (n == inj);
            in1 = 16'($urandom);
            in2 = 16'($urandom);
            if (n == rst_at) begin
                RST = 1'b0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_out", out, 0);
                chk("rst_ovf", ovf, 0);
                chk("rst_dz", dz, 0);
                start = 1'b0;
                @(negedge CLK);
                RST = 1'b1;
                prev_out = '0;
                $display("op a=%h b=%h reset at run cycle %0d", a, b, n);
                return;
            end
            @(posedge CLK); #1;
            n++;
            if (!done && !busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        chk("latency", n, (b == 16'h0000) ? 0 : WD);
        chk("busy_hold", busy_ok, 1);
        chk("busy_end", busy, 0);
        chk("out", out, eq);
        chk("ovf", ovf, eo);
        chk("dz", dz, ez);
        prev_out = eq;
        $display("op a=%h b=%h out=%h ovf=%0d dz=%0d lat=%0d exp=%h", a, b, out, ovf, dz, n, eq);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          sel;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_out", out, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_dz", dz, 0);
        @(negedge CLK);
        RST = 1'b1;

        do_op(16'h1800, 16'h0800, -1, -1);
        do_op(16'h1000, 16'h3000, -1, -1);
        do_op(16'hF000, 16'h0001, -1, -1);
        do_op(16'h1234, 16'h0000, -1, -1);
        do_op(16'h0000, 16'h0000, -1, -1);
        do_op(16'h1800, 16'h0800, 10, -1);
        do_op(16'hFFFF, 16'hFFFF, -1, -1);
        do_op(16'h0000, 16'h0123, -1, -1);
        do_op(16'h1800, 16'h0800, -1, 12);
        do_op(16'h1800, 16'h0800, -1, -1);

        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 7));
            ra  = 16'($urandom);
            if (sel == 0)      rb = 16'h0000;
            else if (sel == 1) rb = 16'($urandom_range(1, 15));
            else               rb = 16'($urandom);
            do_op(ra, rb, (sel == 2) ? int'($urandom_range(0, WD - 2)) : -1, -1);
        end

        @(posedge CLK); #1;
        chk("done_pulse_end", done, 0);
        chk("out_hold_end", out, prev_out);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
